// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and master FSM states.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI
// transaction out, one completion back.
module axil_master
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_we,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   wstrb_q;
    logic                    we_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    arvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;
    logic                    aw_done;
    logic                    w_done;
    logic                    accept;

    // A channel counts as done once its valid is gone or handshakes now.
    assign aw_done = !awvalid_q || m_axil_awready;
    assign w_done  = !wvalid_q || m_axil_wready;
    assign accept  = (state_q == IDLE) && cmd_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready     = 1'b0;
        m_axil_bready = 1'b0;
        m_axil_rready = 1'b0;
        rsp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_we ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                if (aw_done && w_done) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    state_d = RSP;
                end
            end
            RD_ADDR: begin
                if (m_axil_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                we_q      <= cmd_we;
                awvalid_q <= cmd_we;
                wvalid_q  <= cmd_we;
                arvalid_q <= !cmd_we;
                rdata_q   <= '0;
                resp_q    <= RESP_OKAY;
            end
            if (awvalid_q && m_axil_awready) begin
                awvalid_q <= 1'b0;
            end
            if (wvalid_q && m_axil_wready) begin
                wvalid_q <= 1'b0;
            end
            if (arvalid_q && m_axil_arready) begin
                arvalid_q <= 1'b0;
            end
            if (state_q == WR_RESP && m_axil_bvalid) begin
                resp_q <= m_axil_bresp;
            end
            if (state_q == RD_DATA && m_axil_rvalid) begin
                rdata_q <= m_axil_rdata;
                resp_q  <= m_axil_rresp;
            end
        end
    end

    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;

    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_we    = we_q;

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the address width in bits.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, SHALL set the write-strobe width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  SHALL form the request handshake.
REQ-007 cmd_we  in  1  SHALL select write (1) or read (0).
REQ-008 cmd_addr/cmd_wdata/cmd_wstrb  in  ADDR_WIDTH/DATA_WIDTH/STRB_WIDTH  SHALL carry the request fields.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  SHALL form the completion handshake.
REQ-010 rsp_rdata/rsp_resp/rsp_we  out  DATA_WIDTH/2/1  SHALL carry read data, AXI response code and the originating direction.
REQ-011 m_axil_aw*/w*/b*/ar*/r*  SHALL be the full AXI4-Lite master port set (awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready).

Function
REQ-012 The FSM SHALL have states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-013 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid && cmd_ready, and all fields SHALL be registered then.
REQ-014 The cycle after a write is accepted, awvalid and wvalid SHALL both be 1, driven from registers.
REQ-015 awvalid and wvalid SHALL each drop independently on the cycle following their own handshake; AW and W handshakes SHALL be allowed in either order or in the same cycle.
REQ-016 Once both AW and W have handshaken, the FSM SHALL enter WR_RESP with bready=1; on bvalid && bready it SHALL capture bresp and go to RSP.
REQ-017 A read SHALL assert arvalid the cycle after acceptance; on the arready handshake, arvalid SHALL drop, the FSM SHALL enter RD_DATA with rready=1, and the rvalid handshake SHALL capture rdata/rresp and go to RSP.
REQ-018 In RSP, rsp_valid SHALL be 1 with stable outputs until rsp_ready=1, then the FSM SHALL return to IDLE; rsp_rdata SHALL be 0 for writes.
REQ-019 Valid signals SHALL never depend combinationally on ready inputs, and a valid SHALL never be withdrawn before its handshake.
REQ-020 awprot and arprot SHALL be 3'b000; address, data and strobe SHALL stay stable while the corresponding valid is high.
REQ-021 Exactly one transaction SHALL be outstanding; a zero-wait slave SHALL give command-to-rsp_valid latency of 3 cycles for a write and 3 cycles for a read.
REQ-022 SLVERR/DECERR responses SHALL be passed unchanged on rsp_resp, with no retry.

Reset
REQ-023 While rst_n=0, the FSM SHALL go to IDLE and all valid/ready outputs SHALL be 0, except cmd_ready, which SHALL be 1 from the first cycle after reset.
REQ-024 While rst_n=0, the registered address, data, strobe, rsp_rdata and rsp_resp SHALL be 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction and issue no response; the slave is reset concurrently.

Structure
REQ-026 Shared package axil_pkg SHALL hold the AXI response codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the FSM state typedef.
REQ-027 The block SHALL be a single module with no sub-modules.

Verification
REQ-028 Bench pairs axil_master with axil_gpio (N_GPIO=64): write 0x08=FFFF_FFFF, then 0x00=AAAA_5555 -> gpio[31:0]==AAAA_5555, rsp_resp=OKAY, rsp_we=1.
REQ-029 Write 0x08=0, TB drives gpio[31:0]=1234_5678, read 0x00 -> rsp_rdata=1234_5678, rsp_resp=OKAY, rsp_we=0.
REQ-030 Behavioural slave delays wready 4 cycles after awready, then the reverse -> exactly one AW and one W handshake each, one rsp, valids stable until handshake.
REQ-031 Slave returns bresp=SLVERR and rresp=DECERR -> rsp_resp=2'b10 and 2'b11 respectively.
REQ-032 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; accepted the cycle after rsp_ready=1.
REQ-033 Assert rst_n=0 while awvalid=1 -> next cycle all valids 0, FSM IDLE; a following read of 0x0C completes normally.
